// File: rtl/apes_hk_pkg.sv
// ============================================================================
// apes_hk_pkg : shared constants and state type for the HK ADC SPI path
// Rev 1.0
// ============================================================================
`default_nettype none

package apes_hk_pkg;

  localparam int HK_FRAME_BITS = 16;
  localparam int HK_ADDR_W     = 3;
  localparam int HK_CTRL_BITS  = 8;

  localparam int ADD2_POS = 5;
  localparam int ADD1_POS = 4;
  localparam int ADD0_POS = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } hk_state_t;

endpackage

`default_nettype wire

// File: rtl/apes_adc_responder_if.sv
// ============================================================================
// apes_adc_responder_if : SPI pin bundle between HK ADC master and responder
// Rev 1.0
// ============================================================================
`default_nettype none

interface apes_adc_responder_if;

  logic spi_csn;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_csn,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_csn,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );

endinterface

`default_nettype wire

// File: rtl/apes_sync_edge.sv
// ============================================================================
// apes_sync_edge : N-stage synchronizer with rise/fall pulses on the synced value
// Rev 1.0
// ============================================================================
`default_nettype none

module apes_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  wire  clk50,
  input  wire  rst_n,
  input  wire  i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[STAGES-1] & r_dly;

endmodule

`default_nettype wire

// File: rtl/apes_adc_responder.sv
// ============================================================================
// apes_adc_responder : SPI responder emulating the 8-ch 12-bit HK ADC
// Rev 1.0
// ============================================================================
`default_nettype none

module apes_adc_responder
  import apes_hk_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  wire                        clk50,
  input  wire                        rst_n,
  apes_adc_responder_if.slave        spi,
  input  wire [NUM_CH*DATA_W-1:0]    ch_data,
  output logic [HK_ADDR_W-1:0]       cur_addr,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [15:0]                frame_cnt
);

  localparam logic [3:0] c_LAST_BIT = 4'(HK_FRAME_BITS - 1);

  logic w_csn_q, w_csn_rise, w_csn_fall;
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  // Equal depth on all three lines keeps mosi aligned with the sclk edge pulse.
  apes_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk50(clk50), .rst_n(rst_n), .i_d(spi.spi_csn),
    .o_q(w_csn_q), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  apes_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk50(clk50), .rst_n(rst_n), .i_d(spi.spi_sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  apes_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk50(clk50), .rst_n(rst_n), .i_d(spi.spi_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  logic [DATA_W-1:0] w_ch [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ch[g] = ch_data[g*DATA_W +: DATA_W];
  end

  hk_state_t                 r_state;
  logic                      r_miso;
  logic                      r_oe;
  logic [HK_ADDR_W-1:0]      r_cur_addr;
  logic                      r_done;
  logic                      r_err;
  logic [15:0]               r_frame_cnt;
  logic [3:0]                r_bit_cnt;
  logic [HK_FRAME_BITS-1:0]  r_in_sr;
  logic [HK_FRAME_BITS-1:0]  r_out_sr;
  logic                      r_reload;

  logic [HK_FRAME_BITS-1:0]  w_frame;
  logic [HK_FRAME_BITS-1:0]  w_in_next;
  logic [HK_CTRL_BITS-1:0]   w_ctrl;
  logic [HK_ADDR_W-1:0]      w_addr_rx;
  logic                      w_last_edge;
  logic                      w_unused;

  assign w_frame     = HK_FRAME_BITS'(w_ch[r_cur_addr]);
  assign w_in_next   = {r_in_sr[HK_FRAME_BITS-2:0], w_mosi};
  assign w_ctrl      = w_in_next[HK_FRAME_BITS-1 -: HK_CTRL_BITS];
  assign w_addr_rx   = {w_ctrl[ADD2_POS], w_ctrl[ADD1_POS], w_ctrl[ADD0_POS]};
  assign w_last_edge = w_sclk_rise && (r_bit_cnt == c_LAST_BIT);
  assign w_unused    = ^{r_in_sr[HK_FRAME_BITS-1], w_in_next, w_ctrl, r_out_sr[HK_FRAME_BITS-1],
                         w_csn_q, w_sclk_q, w_mosi_rise, w_mosi_fall};

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_cur_addr  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
      r_bit_cnt   <= '0;
      r_in_sr     <= '0;
      r_out_sr    <= '0;
      r_reload    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          r_oe   <= 1'b0;
          if (w_csn_fall) begin
            r_out_sr  <= w_frame;
            r_miso    <= w_frame[HK_FRAME_BITS-1];
            r_oe      <= 1'b1;
            r_bit_cnt <= '0;
            r_reload  <= 1'b0;
            r_state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_csn_rise) begin
            // A final rising edge landing with csn rise still completes the frame.
            if (w_last_edge) begin
              r_in_sr     <= w_in_next;
              r_cur_addr  <= w_addr_rx;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (r_bit_cnt != 4'd0) begin
              r_err <= 1'b1;
            end
            r_state   <= IDLE;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_bit_cnt <= '0;
            r_reload  <= 1'b0;
          end else if (w_sclk_rise) begin
            r_in_sr <= w_in_next;
            if (w_last_edge) begin
              r_cur_addr  <= w_addr_rx;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_bit_cnt   <= '0;
              r_reload    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (w_sclk_fall) begin
            // Back-to-back frames reload the newly addressed channel here.
            if (r_reload) begin
              r_out_sr <= w_frame;
              r_miso   <= w_frame[HK_FRAME_BITS-1];
              r_reload <= 1'b0;
            end else begin
              r_out_sr <= {r_out_sr[HK_FRAME_BITS-2:0], 1'b0};
              r_miso   <= r_out_sr[HK_FRAME_BITS-2];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi.spi_miso    = r_miso;
  assign spi.spi_miso_oe = r_oe;
  assign cur_addr        = r_cur_addr;
  assign frame_done      = r_done;
  assign frame_err       = r_err;
  assign frame_cnt       = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_apes_adc_responder.sv
// ============================================================================
// tb_apes_adc_responder : randomized SPI master against a frame-level ADC model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apes_adc_responder;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int H      = 8;

  logic                     clk50 = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [2:0]               cur_addr;
  logic                     frame_done;
  logic                     frame_err;
  logic [15:0]              frame_cnt;

  apes_adc_responder_if spi_if ();

  apes_adc_responder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .spi        (spi_if.slave),
    .ch_data    (ch_data),
    .cur_addr   (cur_addr),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #10 clk50 = ~clk50;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int err_seen  = 0;

  always @(negedge clk50) begin
    if (frame_done) done_seen++;
    if (frame_err)  err_seen++;
  end

  // Frame-level model of the ADC
  logic [DATA_W-1:0] m_ch [NUM_CH];
  int m_addr = 0;
  int m_cnt  = 0;
  int m_done = 0;
  int m_err  = 0;

  // rxb[0]: miso before the first sclk fall; rxb[k]: miso just before rising edge k
  logic rxb [0:32];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk50);
  endtask

  task automatic set_ch(input int idx, input logic [DATA_W-1:0] val);
    ch_data[idx*DATA_W +: DATA_W] = val;
    m_ch[idx] = val;
  endtask

  task automatic rand_ch();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, DATA_W'($urandom));
  endtask

  task automatic spi_run(input logic [31:0] mo, input int nedges, input bit raise_cs,
                         input int chg_at, input int chg_ch, input logic [DATA_W-1:0] chg_val);
    spi_if.spi_csn = 1'b0;
    cyc(H);
    for (int k = 1; k <= nedges; k++) begin
      @(negedge clk50);
      if (k == 1) rxb[0] = spi_if.spi_miso;
      @(posedge clk50);
      spi_if.spi_sclk = 1'b0;
      spi_if.spi_mosi = mo[32-k];
      cyc(H);
      @(negedge clk50);
      rxb[k] = spi_if.spi_miso;
      @(posedge clk50);
      spi_if.spi_sclk = 1'b1;
      if (k == chg_at) set_ch(chg_ch, chg_val);
      cyc(H);
    end
    if (raise_cs) begin
      spi_if.spi_csn = 1'b1;
      cyc(H);
    end
  endtask

  // A fresh frame presents bit 15 at csn fall; a continued frame presents it on the reload fall.
  task automatic do_frames(input string tag, input logic [7:0] c1, input logic [7:0] c2,
                           input int nedges, input int chg_at, input logic [DATA_W-1:0] chg_val);
    logic [15:0] e1, e2, w1, w2;
    e1 = 16'(m_ch[m_addr]);
    e2 = '0;
    spi_run({c1, 8'($urandom), c2, 8'($urandom)}, nedges, 1'b1, chg_at, m_addr, chg_val);
    if (nedges >= 16) begin
      m_addr = int'(c1[5:3]);
      m_cnt++;
      m_done++;
      e2 = 16'(m_ch[m_addr]);
    end
    if (nedges >= 32) begin
      m_addr = int'(c2[5:3]);
      m_cnt++;
      m_done++;
    end
    if (nedges % 16 != 0) m_err++;
    for (int i = 0; i < 16; i++) begin
      w1[15-i] = rxb[i];
      w2[15-i] = rxb[17+i];
    end
    @(negedge clk50);
    if (nedges >= 16) check_val({tag, "_word1"}, 32'(w1), 32'(e1));
    if (nedges >= 32) check_val({tag, "_word2"}, 32'(w2), 32'(e2));
    check_val({tag, "_addr"}, 32'(cur_addr), 32'(m_addr));
    check_val({tag, "_cnt"}, 32'(frame_cnt), 32'(m_cnt & 16'hFFFF));
    check_val({tag, "_ndone"}, 32'(done_seen), 32'(m_done));
    check_val({tag, "_nerr"}, 32'(err_seen), 32'(m_err));
    check_val({tag, "_oe_idle"}, 32'(spi_if.spi_miso_oe), 32'd0);
    check_val({tag, "_miso_idle"}, 32'(spi_if.spi_miso), 32'd0);
  endtask

  initial begin
    repeat (80000) @(posedge clk50);
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    spi_if.spi_csn  = 1'b1;
    spi_if.spi_sclk = 1'b1;
    spi_if.spi_mosi = 1'b0;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, '0);

    cyc(5);
    @(negedge clk50);
    check_val("rst_miso", 32'(spi_if.spi_miso), 32'd0);
    check_val("rst_oe", 32'(spi_if.spi_miso_oe), 32'd0);
    check_val("rst_addr", 32'(cur_addr), 32'd0);
    check_val("rst_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    cyc(4);

    // sclk activity while deselected
    for (int i = 0; i < 6; i++) begin
      spi_if.spi_sclk = 1'b0; cyc(H);
      spi_if.spi_sclk = 1'b1; cyc(H);
    end
    @(negedge clk50);
    check_val("idle_ndone", 32'(done_seen), 32'd0);
    check_val("idle_miso", 32'(spi_if.spi_miso), 32'd0);
    check_val("idle_oe", 32'(spi_if.spi_miso_oe), 32'd0);

    rand_ch();
    set_ch(0, 12'hABC);
    do_frames("ch0", 8'h18, 8'h00, 16, 0, '0);
    set_ch(3, 12'h123);
    do_frames("ch3", 8'h00, 8'h00, 16, 0, '0);
    set_ch(5, 12'h5A5);
    do_frames("cont", 8'h28, 8'h00, 32, 0, '0);
    do_frames("abort7", 8'h38, 8'h00, 7, 0, '0);
    do_frames("after_abort", 8'h10, 8'h00, 16, 0, '0);

    // ch_data change mid-frame, then re-read the same channel
    do_frames("midchg", {2'b00, 3'(m_addr), 3'b000}, 8'h00, 16, 8, 12'h9E1);
    do_frames("postchg", 8'h00, 8'h00, 16, 0, '0);

    // reset in the middle of a frame
    do_frames("pre_rst", 8'h30, 8'h00, 16, 0, '0);
    spi_run(32'hFFFF_FFFF, 5, 1'b0, 0, 0, '0);
    @(negedge clk50);
    check_val("midrst_oe_active", 32'(spi_if.spi_miso_oe), 32'd1);
    @(posedge clk50);
    rst_n = 1'b0;
    spi_if.spi_csn  = 1'b1;
    spi_if.spi_sclk = 1'b1;
    cyc(2);
    @(negedge clk50);
    check_val("midrst_miso", 32'(spi_if.spi_miso), 32'd0);
    check_val("midrst_oe", 32'(spi_if.spi_miso_oe), 32'd0);
    check_val("midrst_addr", 32'(cur_addr), 32'd0);
    check_val("midrst_cnt", 32'(frame_cnt), 32'd0);
    rst_n  = 1'b1;
    m_addr = 0;
    m_cnt  = 0;
    cyc(4);
    do_frames("post_rst", 8'h08, 8'h00, 16, 0, '0);

    for (int it = 0; it < 16; it++) begin
      int mode;
      rand_ch();
      mode = int'($urandom_range(0, 3));
      case (mode)
        0, 1:    do_frames($sformatf("rnd%0d_single", it), 8'($urandom), 8'($urandom), 16, 0, '0);
        2:       do_frames($sformatf("rnd%0d_cont", it), 8'($urandom), 8'($urandom), 32, 0, '0);
        default: do_frames($sformatf("rnd%0d_abort", it), 8'($urandom), 8'($urandom),
                           int'($urandom_range(1, 15)), 0, '0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
